// File: rtl/ama_riscv_mmio_pkg.sv
// Shared types and constants for the MMIO counter/UART responder.
package ama_riscv_mmio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int UART_DW         = 8;
   localparam int UART_FRAME_BITS = 10;
   localparam int RX_FIFO_DEPTH   = 4;

   // Bit-timer width; modules build their timer type from this.
   function automatic int uart_tmr_w(input int clks_per_bit);
      return $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/ama_riscv_mmio_uart_if.sv
// Core-side MMIO handshake bundle: the core is master, the UART/counter block is slave.
interface ama_riscv_mmio_uart_if;
   import ama_riscv_mmio_pkg::*;

   logic               store_to_uart;
   logic               load_from_uart;
   logic               inst_wb_nop_or_clear;
   logic               mmio_reset_cnt;
   logic [UART_DW-1:0] mmio_uart_data_in;
   logic [31:0]        mmio_instr_cnt;
   logic [31:0]        mmio_cycle_cnt;
   logic [UART_DW-1:0] mmio_uart_data_out;
   logic               mmio_data_out_valid;
   logic               mmio_data_in_ready;

   modport master (
      output store_to_uart, load_from_uart, inst_wb_nop_or_clear, mmio_reset_cnt,
             mmio_uart_data_in,
      input  mmio_instr_cnt, mmio_cycle_cnt, mmio_uart_data_out, mmio_data_out_valid,
             mmio_data_in_ready
   );

   modport slave (
      input  store_to_uart, load_from_uart, inst_wb_nop_or_clear, mmio_reset_cnt,
             mmio_uart_data_in,
      output mmio_instr_cnt, mmio_cycle_cnt, mmio_uart_data_out, mmio_data_out_valid,
             mmio_data_in_ready
   );

endinterface

// File: rtl/ama_riscv_uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, one-cycle byte commit pulse.
module ama_riscv_uart_rx
   import ama_riscv_mmio_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               serial_in,
   output logic [UART_DW-1:0] rx_byte,
   output logic               rx_commit
);
   localparam int   TMR_W   = uart_tmr_w(CLKS_PER_BIT);
   localparam type  tmr_t   = logic [TMR_W-1:0];
   localparam tmr_t TMR_MAX = tmr_t'(CLKS_PER_BIT - 1);
   localparam tmr_t TMR_MID = tmr_t'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]         sync_r;
   logic               rx_s;
   uart_state_t        rx_state_r, rx_state_nx;
   tmr_t               rx_tmr_r, rx_tmr_nx;
   logic [2:0]         rx_bit_r, rx_bit_nx;
   logic [UART_DW-1:0] rx_shift_r, rx_shift_nx;
   logic [UART_DW-1:0] rx_byte_r, rx_byte_nx;
   logic               rx_commit_r, rx_commit_nx;

   // Two-stage synchronizer for the asynchronous pin; idles high like the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], serial_in};
      end
   end

   assign rx_s = sync_r[1];

   // RX next-state: half-bit wait qualifies the start bit, then full-bit steps land mid-bit.
   always_comb begin
      rx_state_nx  = rx_state_r;
      rx_tmr_nx    = rx_tmr_r;
      rx_bit_nx    = rx_bit_r;
      rx_shift_nx  = rx_shift_r;
      rx_byte_nx   = rx_byte_r;
      rx_commit_nx = 1'b0;
      case (rx_state_r)
         IDLE: begin
            rx_tmr_nx = tmr_t'(0);
            rx_bit_nx = 3'd0;
            if (!rx_s) begin
               rx_state_nx = START;
            end else begin
               rx_state_nx = IDLE;
            end
         end
         START: begin
            if (rx_tmr_r == TMR_MID) begin
               rx_tmr_nx = tmr_t'(0);
               if (rx_s) begin
                  rx_state_nx = IDLE;
               end else begin
                  rx_state_nx = DATA;
               end
            end else begin
               rx_tmr_nx = rx_tmr_r + tmr_t'(1);
            end
         end
         DATA: begin
            if (rx_tmr_r == TMR_MAX) begin
               rx_tmr_nx   = tmr_t'(0);
               rx_shift_nx = {rx_s, rx_shift_r[UART_DW-1:1]};
               rx_bit_nx   = rx_bit_r + 3'd1;
               if (rx_bit_r == 3'd7) begin
                  rx_state_nx = STOP;
               end else begin
                  rx_state_nx = DATA;
               end
            end else begin
               rx_tmr_nx = rx_tmr_r + tmr_t'(1);
            end
         end
         STOP: begin
            if (rx_tmr_r == TMR_MAX) begin
               rx_tmr_nx   = tmr_t'(0);
               rx_state_nx = IDLE;
               if (rx_s) begin
                  rx_commit_nx = 1'b1;
                  rx_byte_nx   = rx_shift_r;
               end else begin
                  rx_commit_nx = 1'b0;
               end
            end else begin
               rx_tmr_nx = rx_tmr_r + tmr_t'(1);
            end
         end
         default: begin
            rx_state_nx = IDLE;
         end
      endcase
   end

   // RX state and datapath registers; reset drops any partial byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_r  <= IDLE;
         rx_tmr_r    <= tmr_t'(0);
         rx_bit_r    <= 3'd0;
         rx_shift_r  <= 8'h00;
         rx_byte_r   <= 8'h00;
         rx_commit_r <= 1'b0;
      end else begin
         rx_state_r  <= rx_state_nx;
         rx_tmr_r    <= rx_tmr_nx;
         rx_bit_r    <= rx_bit_nx;
         rx_shift_r  <= rx_shift_nx;
         rx_byte_r   <= rx_byte_nx;
         rx_commit_r <= rx_commit_nx;
      end
   end

   assign rx_byte   = rx_byte_r;
   assign rx_commit = rx_commit_r;

endmodule

// File: rtl/ama_riscv_mmio_uart.sv
// MMIO responder: instruction/cycle counters, UART TX for core stores, UART RX for core loads.
// Define MMIO_UART_RX_FIFO_EN to put a 4-entry FIFO between the receiver and the load data.
module ama_riscv_mmio_uart
   import ama_riscv_mmio_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 rst,
   ama_riscv_mmio_uart_if.slave mmio,
   input  logic                 serial_in,
   output logic                 serial_out
);
   localparam int   TMR_W   = uart_tmr_w(CLKS_PER_BIT);
   localparam type  tmr_t   = logic [TMR_W-1:0];
   localparam tmr_t TMR_MAX = tmr_t'(CLKS_PER_BIT - 1);

   logic [31:0]        cycle_cnt_r;
   logic [31:0]        instr_cnt_r;

   uart_state_t        tx_state_r, tx_state_nx;
   tmr_t               tx_tmr_r, tx_tmr_nx;
   logic [3:0]         tx_bit_r, tx_bit_nx;
   logic [UART_DW-1:0] tx_shift_r, tx_shift_nx;
   logic               tx_done_s;
   logic               tx_serial_nx;
   logic               tx_serial_r;
   logic               tx_ready_r;

   logic [UART_DW-1:0] rx_byte_s;
   logic               rx_commit_s;

   // Counters: clear beats increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_r <= 32'd0;
         instr_cnt_r <= 32'd0;
      end else if (mmio.mmio_reset_cnt) begin
         cycle_cnt_r <= 32'd0;
         instr_cnt_r <= 32'd0;
      end else begin
         cycle_cnt_r <= cycle_cnt_r + 32'd1;
         if (!mmio.inst_wb_nop_or_clear) begin
            instr_cnt_r <= instr_cnt_r + 32'd1;
         end
      end
   end

   assign mmio.mmio_cycle_cnt = cycle_cnt_r;
   assign mmio.mmio_instr_cnt = instr_cnt_r;

   // TX next-state; tx_bit counts frame positions so DATA covers positions 1..8.
   always_comb begin
      tx_state_nx  = tx_state_r;
      tx_tmr_nx    = tx_tmr_r;
      tx_bit_nx    = tx_bit_r;
      tx_shift_nx  = tx_shift_r;
      tx_done_s    = (tx_tmr_r == TMR_MAX);
      tx_serial_nx = 1'b1;
      case (tx_state_r)
         IDLE: begin
            tx_tmr_nx = tmr_t'(0);
            tx_bit_nx = 4'd0;
            if (mmio.store_to_uart) begin
               tx_shift_nx = mmio.mmio_uart_data_in;
               tx_state_nx = START;
            end else begin
               tx_state_nx = IDLE;
            end
         end
         START: begin
            if (tx_done_s) begin
               tx_tmr_nx   = tmr_t'(0);
               tx_bit_nx   = 4'd1;
               tx_state_nx = DATA;
            end else begin
               tx_tmr_nx = tx_tmr_r + tmr_t'(1);
            end
         end
         DATA: begin
            if (tx_done_s) begin
               tx_tmr_nx   = tmr_t'(0);
               tx_bit_nx   = tx_bit_r + 4'd1;
               tx_shift_nx = {1'b0, tx_shift_r[UART_DW-1:1]};
               if (tx_bit_r == 4'(UART_FRAME_BITS - 2)) begin
                  tx_state_nx = STOP;
               end else begin
                  tx_state_nx = DATA;
               end
            end else begin
               tx_tmr_nx = tx_tmr_r + tmr_t'(1);
            end
         end
         STOP: begin
            if (tx_done_s) begin
               tx_tmr_nx   = tmr_t'(0);
               tx_state_nx = IDLE;
            end else begin
               tx_tmr_nx = tx_tmr_r + tmr_t'(1);
            end
         end
         default: begin
            tx_state_nx = IDLE;
         end
      endcase

      // Line level follows the state being entered so serial_out can be a flop.
      case (tx_state_nx)
         IDLE:    tx_serial_nx = 1'b1;
         START:   tx_serial_nx = 1'b0;
         DATA:    tx_serial_nx = tx_shift_nx[0];
         STOP:    tx_serial_nx = 1'b1;
         default: tx_serial_nx = 1'b1;
      endcase
   end

   // TX registers; reset returns the line high at once, aborting any frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r  <= IDLE;
         tx_tmr_r    <= tmr_t'(0);
         tx_bit_r    <= 4'd0;
         tx_shift_r  <= 8'h00;
         tx_serial_r <= 1'b1;
         tx_ready_r  <= 1'b1;
      end else begin
         tx_state_r  <= tx_state_nx;
         tx_tmr_r    <= tx_tmr_nx;
         tx_bit_r    <= tx_bit_nx;
         tx_shift_r  <= tx_shift_nx;
         tx_serial_r <= tx_serial_nx;
         tx_ready_r  <= (tx_state_nx == IDLE);
      end
   end

   assign serial_out              = tx_serial_r;
   assign mmio.mmio_data_in_ready = tx_ready_r;

   ama_riscv_uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .serial_in (serial_in),
      .rx_byte   (rx_byte_s),
      .rx_commit (rx_commit_s)
   );

`ifdef MMIO_UART_RX_FIFO_EN
   logic [UART_DW-1:0] fifo_mem_r [RX_FIFO_DEPTH];
   logic [1:0]         fifo_wr_r;
   logic [1:0]         fifo_rd_r;
   logic [2:0]         fifo_cnt_r;
   logic               fifo_push_s;
   logic               fifo_pop_s;

   // A full FIFO still takes a byte when the head leaves in the same cycle.
   always_comb begin
      fifo_pop_s  = mmio.load_from_uart && (fifo_cnt_r != 3'd0);
      fifo_push_s = rx_commit_s && ((fifo_cnt_r != 3'(RX_FIFO_DEPTH)) || fifo_pop_s);
   end

   // FIFO storage, wrapping pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= 8'h00;
         end
         fifo_wr_r  <= 2'd0;
         fifo_rd_r  <= 2'd0;
         fifo_cnt_r <= 3'd0;
      end else begin
         if (fifo_push_s) begin
            fifo_mem_r[fifo_wr_r] <= rx_byte_s;
            fifo_wr_r             <= fifo_wr_r + 2'd1;
         end
         if (fifo_pop_s) begin
            fifo_rd_r <= fifo_rd_r + 2'd1;
         end
         fifo_cnt_r <= fifo_cnt_r + {2'b00, fifo_push_s} - {2'b00, fifo_pop_s};
      end
   end

   assign mmio.mmio_uart_data_out  = fifo_mem_r[fifo_rd_r];
   assign mmio.mmio_data_out_valid = (fifo_cnt_r != 3'd0);
`else
   logic [UART_DW-1:0] rx_data_r;
   logic               rx_valid_r;

   // Single load register: a commit overwrites and wins over a same-cycle load.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data_r  <= 8'h00;
         rx_valid_r <= 1'b0;
      end else if (rx_commit_s) begin
         rx_data_r  <= rx_byte_s;
         rx_valid_r <= 1'b1;
      end else if (mmio.load_from_uart) begin
         rx_valid_r <= 1'b0;
      end
   end

   assign mmio.mmio_uart_data_out  = rx_data_r;
   assign mmio.mmio_data_out_valid = rx_valid_r;
`endif

endmodule
